// File: rtl/seq_alu.sv
// seq_alu: clocked W-bit ALU. Single-cycle add/sub/logic/compare, plus
// multi-cycle unsigned shift-add multiply and restoring divide, with a
// Busy/Done handshake. Q is 2W bits wide and holds until the next completion.
module seq_alu #(
  parameter int W = 8
) (
  input  logic           Clock,
  input  logic           Resetn,
  input  logic           Start,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  input  logic [2:0]     Sel,
  output logic [2*W-1:0] Q,
  output logic           Busy,
  output logic           Done,
  output logic           DivZero
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t         state, state_n;
  logic [CW-1:0]  count, count_n;
  logic [W-1:0]   a_reg, a_n;
  logic [W-1:0]   b_reg, b_n;
  // Working register shared by both iterative ops: {high half, low half}.
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting into quotient}.
  logic [2*W-1:0] acc, acc_n;
  logic [2*W-1:0] q_n;
  logic           done_n;
  logic           dz_n;
  logic [2*W-1:0] acc_step;

  // Single-cycle results; operands zero-extended to 2W bits.
  function automatic logic [2*W-1:0] alu_result(input logic [2:0] sel,
                                                input logic [W-1:0] a,
                                                input logic [W-1:0] b);
    logic [2*W-1:0] ax, bx, r;
    ax = {{W{1'b0}}, a};
    bx = {{W{1'b0}}, b};
    r  = '0;
    case (sel)
      3'b000:  r = ax + bx;
      3'b001:  r = ax - bx;
      3'b010:  r = ax & bx;
      3'b011:  r = ax | bx;
      3'b100:  r = ax ^ bx;
      3'b111:  r = {{(2*W-3){1'b0}}, (a > b), (a == b), (a < b)};
      default: r = '0;
    endcase
    return r;
  endfunction

  // One shift-add iteration: add multiplicand to the high half when the
  // current multiplier LSB is set, then shift the whole register right.
  function automatic logic [2*W-1:0] mul_step(input logic [2*W-1:0] cur,
                                              input logic [W-1:0]   mcand);
    logic [W:0] sum;
    sum = {1'b0, cur[2*W-1:W]} + (cur[0] ? {1'b0, mcand} : {(W+1){1'b0}});
    return {sum, cur[W-1:1]};
  endfunction

  // One restoring-divide iteration: shift the next dividend bit into the
  // remainder, subtract the divisor if it fits, and shift in the quotient bit.
  function automatic logic [2*W-1:0] div_step(input logic [2*W-1:0] cur,
                                              input logic [W-1:0]   dvsr);
    logic [W:0]   trial;
    logic [W-1:0] diff;
    trial = {cur[2*W-1:W], cur[W-1]};
    diff  = trial[W-1:0] - dvsr;
    if (trial >= {1'b0, dvsr}) return {diff, cur[W-2:0], 1'b1};
    else                       return {trial[W-1:0], cur[W-2:0], 1'b0};
  endfunction

  // Next-state and next-register logic for the whole datapath.
  always_comb begin
    state_n  = state;
    count_n  = count;
    a_n      = a_reg;
    b_n      = b_reg;
    acc_n    = acc;
    q_n      = Q;
    done_n   = 1'b0;
    dz_n     = DivZero;
    acc_step = '0;
    case (state)
      IDLE: begin
        if (Start) begin
          if (Sel == 3'b101) begin
            a_n     = A;
            b_n     = B;
            acc_n   = {{W{1'b0}}, B};
            count_n = CW'(W);
            state_n = MUL;
          end else if (Sel == 3'b110 && B != '0) begin
            a_n     = A;
            b_n     = B;
            acc_n   = {{W{1'b0}}, A};
            count_n = CW'(W);
            state_n = DIV;
          end else if (Sel == 3'b110) begin
            q_n    = {A, {W{1'b1}}};
            dz_n   = 1'b1;
            done_n = 1'b1;
          end else begin
            q_n    = alu_result(Sel, A, B);
            dz_n   = 1'b0;
            done_n = 1'b1;
          end
        end
      end
      MUL, DIV: begin
        acc_step = (state == MUL) ? mul_step(acc, a_reg) : div_step(acc, b_reg);
        acc_n    = acc_step;
        count_n  = count - CW'(1);
        if (count == CW'(1)) begin
          q_n     = acc_step;
          done_n  = 1'b1;
          dz_n    = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Register all state and outputs; reset aborts any operation in flight.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state   <= IDLE;
      count   <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      Q       <= '0;
      Done    <= 1'b0;
      DivZero <= 1'b0;
    end else begin
      state   <= state_n;
      count   <= count_n;
      a_reg   <= a_n;
      b_reg   <= b_n;
      acc     <= acc_n;
      Q       <= q_n;
      Done    <= done_n;
      DivZero <= dz_n;
    end
  end

  assign Busy = (state != IDLE);

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at W=8 (full scenario set) plus W=16 and W=4.
module tb_seq_alu;

  logic clk = 1'b0;
  logic rst_n;
  int   total  = 0;
  int   passed = 0;

  logic        start8, busy8, done8, dz8;
  logic [7:0]  a8, b8;
  logic [2:0]  sel8;
  logic [15:0] q8;

  logic        start16, busy16, done16, dz16;
  logic [15:0] a16, b16;
  logic [2:0]  sel16;
  logic [31:0] q16;

  logic        start4, busy4, done4, dz4;
  logic [3:0]  a4, b4;
  logic [2:0]  sel4;
  logic [7:0]  q4;

  always #5 clk = ~clk;

  seq_alu #(.W(8)) u8 (
    .Clock(clk), .Resetn(rst_n), .Start(start8), .A(a8), .B(b8), .Sel(sel8),
    .Q(q8), .Busy(busy8), .Done(done8), .DivZero(dz8));

  seq_alu #(.W(16)) u16 (
    .Clock(clk), .Resetn(rst_n), .Start(start16), .A(a16), .B(b16), .Sel(sel16),
    .Q(q16), .Busy(busy16), .Done(done16), .DivZero(dz16));

  seq_alu #(.W(4)) u4 (
    .Clock(clk), .Resetn(rst_n), .Start(start4), .A(a4), .B(b4), .Sel(sel4),
    .Q(q4), .Busy(busy4), .Done(done4), .DivZero(dz4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start8 = 0; a8 = 0; b8 = 0; sel8 = 0;
    start16 = 0; a16 = 0; b16 = 0; sel16 = 0;
    start4 = 0; a4 = 0; b4 = 0; sel4 = 0;
    tick(); tick();
    total++; if ({q8, busy8, done8, dz8} !== 19'h0) $display("FAIL reset8: got q=%h b=%b d=%b z=%b want all 0", q8, busy8, done8, dz8); else passed++;
    total++; if ({q16, busy16, done16, dz16} !== 35'h0) $display("FAIL reset16: got q=%h b=%b d=%b want all 0", q16, busy16, done16); else passed++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add();
    start8 = 1; sel8 = 3'b000; a8 = 8'd200; b8 = 8'd100;
    tick();
    start8 = 0;
    total++; if (q8 !== 16'h012C || done8 !== 1'b1 || busy8 !== 1'b0) $display("FAIL add: got q=%h done=%b busy=%b want 012c 1 0", q8, done8, busy8); else passed++;
    tick();
    total++; if (done8 !== 1'b0 || q8 !== 16'h012C || busy8 !== 1'b0) $display("FAIL add_hold: got q=%h done=%b busy=%b want 012c 0 0", q8, done8, busy8); else passed++;
  endtask

  task automatic test_back_to_back();
    start8 = 1; sel8 = 3'b001; a8 = 8'd5; b8 = 8'd7;
    tick();
    total++; if (q8 !== 16'hFFFE || done8 !== 1'b1) $display("FAIL sub: got q=%h done=%b want fffe 1", q8, done8); else passed++;
    sel8 = 3'b111; a8 = 8'h33; b8 = 8'h33;
    tick();
    start8 = 0;
    total++; if (q8 !== 16'h0002 || done8 !== 1'b1) $display("FAIL cmp_eq: got q=%h done=%b want 0002 1", q8, done8); else passed++;
    a8 = 8'h10; b8 = 8'h20; start8 = 1;
    tick();
    start8 = 0;
    total++; if (q8 !== 16'h0001) $display("FAIL cmp_lt: got q=%h want 0001", q8); else passed++;
    sel8 = 3'b100; a8 = 8'hF0; b8 = 8'h3C; start8 = 1;
    tick();
    total++; if (q8 !== 16'h00CC) $display("FAIL xor: got q=%h want 00cc", q8); else passed++;
    sel8 = 3'b011;
    tick();
    start8 = 0;
    total++; if (q8 !== 16'h00FC) $display("FAIL or: got q=%h want 00fc", q8); else passed++;
    tick();
    total++; if (done8 !== 1'b0) $display("FAIL b2b_done_drop: got %b want 0", done8); else passed++;
  endtask

  task automatic test_mul();
    int busy_cycles;
    logic bad;
    busy_cycles = 0; bad = 0;
    start8 = 1; sel8 = 3'b101; a8 = 8'd255; b8 = 8'd255;
    tick();
    start8 = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy8 === 1'b1) busy_cycles++;
      if (done8 !== 1'b0) bad = 1;
      a8 = 8'($urandom); b8 = 8'($urandom); sel8 = 3'($urandom_range(0, 7));
      tick();
    end
    total++; if (busy_cycles != 8 || bad) $display("FAIL mul_busy: got busy_cycles=%0d early_done=%b want 8 0", busy_cycles, bad); else passed++;
    total++; if (q8 !== 16'hFE01 || done8 !== 1'b1 || busy8 !== 1'b0 || dz8 !== 1'b0) $display("FAIL mul_result: got q=%h done=%b busy=%b dz=%b want fe01 1 0 0", q8, done8, busy8, dz8); else passed++;
    tick();
    total++; if (done8 !== 1'b0 || q8 !== 16'hFE01) $display("FAIL mul_hold: got q=%h done=%b want fe01 0", q8, done8); else passed++;
  endtask

  task automatic test_div();
    start8 = 1; sel8 = 3'b110; a8 = 8'd200; b8 = 8'd7;
    tick();
    start8 = 0;
    total++; if (busy8 !== 1'b1 || done8 !== 1'b0) $display("FAIL div_start: got busy=%b done=%b want 1 0", busy8, done8); else passed++;
    repeat (7) tick();
    total++; if (busy8 !== 1'b1 || done8 !== 1'b0) $display("FAIL div_early: got busy=%b done=%b want 1 0", busy8, done8); else passed++;
    tick();
    total++; if (q8 !== 16'h041C || done8 !== 1'b1 || busy8 !== 1'b0 || dz8 !== 1'b0) $display("FAIL div_result: got q=%h done=%b busy=%b dz=%b want 041c 1 0 0", q8, done8, busy8, dz8); else passed++;
    start8 = 1; sel8 = 3'b110; a8 = 8'h5A; b8 = 8'h00;
    tick();
    start8 = 0;
    total++; if (q8 !== 16'h5AFF || dz8 !== 1'b1 || done8 !== 1'b1 || busy8 !== 1'b0) $display("FAIL divzero: got q=%h dz=%b done=%b busy=%b want 5aff 1 1 0", q8, dz8, done8, busy8); else passed++;
    tick();
    total++; if (dz8 !== 1'b1 || done8 !== 1'b0) $display("FAIL divzero_hold: got dz=%b done=%b want 1 0", dz8, done8); else passed++;
    start8 = 1; sel8 = 3'b010; a8 = 8'hF0; b8 = 8'h3C;
    tick();
    start8 = 0;
    total++; if (q8 !== 16'h0030 || dz8 !== 1'b0) $display("FAIL and_clear_dz: got q=%h dz=%b want 0030 0", q8, dz8); else passed++;
  endtask

  task automatic test_ignore_start();
    start8 = 1; sel8 = 3'b110; a8 = 8'h01; b8 = 8'h00;
    tick();
    start8 = 1; sel8 = 3'b101; a8 = 8'd13; b8 = 8'd11;
    tick();
    start8 = 0;
    for (int c = 1; c < 8; c++) begin
      if (c >= 2 && c <= 5) begin
        start8 = 1; sel8 = 3'b000; a8 = 8'd1; b8 = 8'd1;
      end else begin
        start8 = 0;
      end
      tick();
      if (c == 5) begin
        total++; if (busy8 !== 1'b1 || done8 !== 1'b0) $display("FAIL ignore_busy: got busy=%b done=%b want 1 0", busy8, done8); else passed++;
      end
    end
    start8 = 0;
    tick();
    total++; if (q8 !== 16'h008F || done8 !== 1'b1 || dz8 !== 1'b0) $display("FAIL ignore_result: got q=%h done=%b dz=%b want 008f 1 0", q8, done8, dz8); else passed++;
  endtask

  task automatic test_abort();
    logic seen;
    seen = 0;
    start8 = 1; sel8 = 3'b101; a8 = 8'd9; b8 = 8'd9;
    tick();
    start8 = 0;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    total++; if (q8 !== 16'h0 || busy8 !== 1'b0 || done8 !== 1'b0) $display("FAIL abort_reset: got q=%h busy=%b done=%b want 0 0 0", q8, busy8, done8); else passed++;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8 !== 1'b0 || busy8 !== 1'b0 || q8 !== 16'h0) seen = 1;
    end
    total++; if (seen) $display("FAIL abort_no_done: got late activity=%b want 0", seen); else passed++;
  endtask

  task automatic test_w16();
    logic [2:0]  sels[4]  = '{3'b101, 3'b110, 3'b110, 3'b000};
    logic [15:0] as[4]    = '{16'hFFFF, 16'd1000, 16'h1234, 16'hFFFF};
    logic [15:0] bs[4]    = '{16'hFFFF, 16'd7, 16'h0000, 16'h0001};
    logic [31:0] qs[4]    = '{32'hFFFE0001, 32'h0006008E, 32'h1234FFFF, 32'h00010000};
    logic        dzs[4]   = '{1'b0, 1'b0, 1'b1, 1'b0};
    int          extra[4] = '{16, 16, 0, 0};
    for (int t = 0; t < 4; t++) begin
      logic bad;
      bad = 0;
      start16 = 1; sel16 = sels[t]; a16 = as[t]; b16 = bs[t];
      tick();
      start16 = 0;
      for (int c = 0; c < extra[t]; c++) begin
        if (busy16 !== 1'b1 || done16 !== 1'b0) bad = 1;
        a16 = 16'($urandom);
        tick();
      end
      total++; if (bad || q16 !== qs[t] || done16 !== 1'b1 || busy16 !== 1'b0 || dz16 !== dzs[t]) $display("FAIL w16_op%0d: got q=%h done=%b busy=%b dz=%b early=%b want %h 1 0 %b 0", t, q16, done16, busy16, dz16, bad, qs[t], dzs[t]); else passed++;
    end
    tick();
  endtask

  task automatic test_w4();
    logic [2:0] sels[6]  = '{3'b101, 3'b000, 3'b001, 3'b110, 3'b111, 3'b110};
    logic [3:0] as[6]    = '{4'hF, 4'd9, 4'd3, 4'd13, 4'd5, 4'd7};
    logic [3:0] bs[6]    = '{4'hF, 4'd8, 4'd5, 4'd3, 4'd9, 4'd0};
    logic [7:0] qs[6]    = '{8'hE1, 8'h11, 8'hFE, 8'h14, 8'h01, 8'h7F};
    logic       dzs[6]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int         extra[6] = '{4, 0, 0, 4, 0, 0};
    for (int t = 0; t < 6; t++) begin
      logic bad;
      bad = 0;
      start4 = 1; sel4 = sels[t]; a4 = as[t]; b4 = bs[t];
      tick();
      start4 = 0;
      for (int c = 0; c < extra[t]; c++) begin
        if (busy4 !== 1'b1 || done4 !== 1'b0) bad = 1;
        tick();
      end
      total++; if (bad || q4 !== qs[t] || done4 !== 1'b1 || busy4 !== 1'b0 || dz4 !== dzs[t]) $display("FAIL w4_op%0d: got q=%h done=%b busy=%b dz=%b early=%b want %h 1 0 %b 0", t, q4, done4, busy4, dz4, bad, qs[t], dzs[t]); else passed++;
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_mul();
    test_div();
    test_ignore_start();
    test_abort();
    test_w16();
    test_w4();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
